// File: rtl/mod_mul_iter_pkg.sv
// Shared constants and types for the bit-serial Montgomery multiplier.
// Default modulus is the NIST P-192 prime, with R = 2^192.
package mod_mul_pkg;

    localparam int unsigned N = 192;

    localparam logic [N-1:0] P192_M =
        192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF;

    // Domain conversion helpers: R mod M = 2^64+1, R^2 mod M = 2^128+2^65+1
    localparam logic [N-1:0] R_MOD_M =
        192'h00000000_00000000_00000000_00000001_00000000_00000001;
    localparam logic [N-1:0] R2_MOD_M =
        192'h00000000_00000001_00000000_00000002_00000000_00000001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mod_mul_iter_if.sv
// Request/result bundle for mod_mul_iter: operands and start in, result and done out.
interface mod_mul_iter_if #(
    parameter int unsigned N = mod_mul_pkg::N
);
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] z;
    logic         done;

    modport master (output start, output x, output y, input z, input done);
    modport slave  (input start, input x, input y, output z, output done);
endinterface

// File: rtl/mod_mul_iter_mont_step.sv
// One radix-2 Montgomery iteration: A' = (A + xi*Y [+ M when odd]) / 2.
// Purely combinational; A < 2M in gives A' < 2M out.
module mont_step #(
    parameter int unsigned N = 192
) (
    input  logic [N+1:0] a,
    input  logic         xi,
    input  logic [N-1:0] y,
    input  logic [N-1:0] m,
    output logic [N+1:0] a_next
);

    // Intermediate sum can reach just under 4M, so one extra bit over A.
    logic [N+2:0] t;

    always_comb begin
        t = {1'b0, a} + (xi ? {3'b000, y} : '0);
        if (t[0]) begin
            t = t + {3'b000, m};
        end
        a_next = t[N+2:1];
    end

endmodule

// File: rtl/mod_mul_iter.sv
// Bit-serial Montgomery multiplier z = x*y*2^-N mod M, one bit of x per cycle.
// Holds the control FSM, operand/accumulator registers and the final reduction.
module mod_mul_iter #(
    parameter int unsigned  N = mod_mul_pkg::N,
    parameter logic [N-1:0] M = mod_mul_pkg::P192_M
) (
    input  logic           clk,
    input  logic           rst,
    mod_mul_iter_if.slave  bus
);
    import mod_mul_pkg::*;

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state;
    logic [N-1:0]   xr;
    logic [N-1:0]   yr;
    logic [N+1:0]   acc;
    logic [N+1:0]   acc_next;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   z_q;
    logic           done_q;
    logic [N+1:0]   acc_minus;
    logic [N-1:0]   final_z;

    mont_step #(.N(N)) u_step (
        .a      (acc),
        .xi     (xr[cnt]),
        .y      (yr),
        .m      (M),
        .a_next (acc_next)
    );

    always_comb begin
        acc_minus = acc - {2'b00, M};
        final_z   = (acc >= {2'b00, M}) ? acc_minus[N-1:0] : acc[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            xr     <= '0;
            yr     <= '0;
            acc    <= '0;
            cnt    <= '0;
            z_q    <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        xr    <= bus.x;
                        yr    <= bus.y;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    z_q   <= final_z;
                    state <= DONE;
                end
                DONE: begin
                    // done is raised on the first DONE edge, so release only
                    // takes effect once a result has actually been flagged.
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else if (!bus.start) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.z    = z_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mod_mul_iter.sv
// Self-checking bench for mod_mul_iter: directed vectors plus random operands
// compared against an arithmetic Montgomery-product model.
module tb_mod_mul_iter;
    import mod_mul_pkg::*;

    localparam int unsigned W = 192;
    localparam logic [W-1:0] MOD = P192_M;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [W-1:0] rinv;

    always #5 clk = ~clk;

    mod_mul_iter_if #(.N(W)) bus ();

    mod_mul_iter #(.N(W), .M(MOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // z such that z*R == a*b (mod M), using a precomputed inverse of R.
    function automatic logic [W-1:0] ref_mont(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [2*W-1:0] mm;
        mm = {{W{1'b0}}, MOD};
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        p  = p % mm;
        p  = p * {{W{1'b0}}, rinv};
        p  = p % mm;
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return v % MOD;
    endfunction

    // Raises start with the operands, waits for done; start is left high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int cyc);
        @(negedge clk);
        bus.x = a;
        bus.y = b;
        bus.start = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (!bus.done && cyc < 400);
        res = bus.z;
        chk("done_seen", {191'b0, bus.done}, {191'b0, 1'b1});
    endtask

    task automatic release_start();
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_release", {191'b0, bus.done}, '0);
    endtask

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] h;
        int cyc;
        bit saw_done;

        // Inverse of R: halve 1 modulo M, N times.
        h = 1;
        for (int k = 0; k < int'(W); k++) begin
            logic [W:0] t;
            t = {1'b0, h};
            if (t[0]) t = t + {1'b0, MOD};
            t = t >> 1;
            h = t[W-1:0];
        end
        rinv = h;

        bus.start = 1'b0;
        bus.x = '0;
        bus.y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_z", bus.z, '0);
        chk("reset_done", {191'b0, bus.done}, '0);
        @(negedge clk);
        rst = 1'b0;

        run_op(192'hF7, 192'h0A, res, cyc);
        chk("vec1", res, 192'h00000000000009A5FFFFFFFFFFFFF65A0000000000000000);
        release_start();

        run_op(R2_MOD_M, 192'h0B, res, cyc);
        chk("to_domain", res, 192'h0000000000000000000000000000000B000000000000000B);
        release_start();

        run_op(R_MOD_M, R_MOD_M, res, cyc);
        chk("one_times_one", res, R_MOD_M);
        release_start();

        run_op(R_MOD_M, 192'h0000000000000000000000000000000B000000000000000B, res, cyc);
        chk("one_times_11", res, 192'h0000000000000000000000000000000B000000000000000B);
        chk("latency", W'(cyc), W'(194));

        // start held: no restart, result stable even with new operands presented
        bus.x = 192'h5;
        bus.y = 192'h7;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 0 || k == 19) begin
                chk("hold_done", {191'b0, bus.done}, {191'b0, 1'b1});
                chk("hold_z", bus.z, 192'h0000000000000000000000000000000B000000000000000B);
            end
        end
        release_start();

        a = rand_operand();
        b = rand_operand();
        run_op(a, b, res, cyc);
        chk("fresh_after_release", res, ref_mont(a, b));
        release_start();

        // reset partway through the iterations
        @(negedge clk);
        bus.x = 192'hF7;
        bus.y = 192'h0A;
        bus.start = 1'b1;
        @(posedge clk);
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_z", bus.z, '0);
        chk("midrst_done", {191'b0, bus.done}, '0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 250; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("midrst_no_done", {191'b0, saw_done}, '0);
        run_op(192'hF7, 192'h0A, res, cyc);
        chk("vec1_after_rst", res, 192'h00000000000009A5FFFFFFFFFFFFF65A0000000000000000);
        release_start();

        // boundary operands
        run_op(MOD - 1, MOD - 1, res, cyc);
        chk("max_operands", res, ref_mont(MOD - 1, MOD - 1));
        release_start();
        run_op('0, MOD - 1, res, cyc);
        chk("zero_operand", res, '0);
        release_start();

        for (int n = 0; n < 6; n++) begin
            a = rand_operand();
            b = rand_operand();
            run_op(a, b, res, cyc);
            chk("random", res, ref_mont(a, b));
            release_start();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_mul_iter.md
Name: mod_mul_iter

Overview:
- Bit-serial radix-2 Montgomery modular multiplier: z = x·y·2^-N mod M, with R = 2^N.
- Default configuration is the NIST P-192 prime, N = 192. This is the core multiply primitive for RSA/ECC exponentiation datapaths.
- Operands and result are in the Montgomery domain. Conversion into the domain is done by multiplying with R² mod M; conversion out is done by multiplying with 1.

Parameters:
- N, 192, operand/result width in bits; R = 2^N.
- M, 192'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFF, modulus. Must be odd and satisfy M < 2^N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level request. Operands are captured when start is sampled high in IDLE.
- x  input  N  multiplicand. Caller guarantees x < M.
- y  input  N  multiplier. Caller guarantees y < M.
- z  output  N  result x·y·2^-N mod M, always fully reduced (z < M).
- done  output  1  result valid. Held high in DONE.

Behaviour:
- Reset (rst=1 at a clock edge): state←IDLE, z←0, done←0, accumulator and counter←0.
  - Reset takes priority over every other event.
  - Reset mid-operation abandons the computation; no done pulse is produced.
- FSM states: IDLE, RUN, FINAL, DONE.
  - IDLE: when start=1 at an edge, latch x→Xr and y→Yr, clear A (N+2 bits), clear counter i, go to RUN.
  - RUN: one iteration per cycle, i = 0..N-1.
    - T = A + (Xr[i] ? Yr : 0).
    - If T is odd, T = T + M.
    - A ← T >> 1.
    - After iteration N-1, go to FINAL.
  - FINAL: z ← (A ≥ M) ? A − M : A (low N bits). Go to DONE.
  - DONE: done=1 and z is held stable. When start is sampled 0, go to IDLE and clear done on that edge.
- Invariant: A < 2M throughout, so A needs N+2 bits internally.
- Latency: start sampled at edge k gives N RUN cycles, then FINAL at edge k+N+1; z and done are valid from edge k+N+2 (194 cycles for N=192).
- start held high continuously does not cause a restart. A new operation requires start to return low (which releases DONE) and rise again.
- x/y changes after capture are ignored. start changes during RUN/FINAL are ignored.
- z retains the last result until the next FINAL or reset. done is 0 in IDLE, RUN and FINAL.
- x or y ≥ M is out of contract. The output is then still < 2^N but unspecified.

Decomposition:
- Shared package mod_mul_pkg:
  - width constant N = 192.
  - P-192 modulus constant.
  - Precomputed R mod M = 2^64+1 and R² mod M = 2^128+2^65+1, for users and benches.
  - State enum {IDLE, RUN, FINAL, DONE}.
- One natural sub-module, mont_step: purely combinational single iteration (A, xi, Yr, M) → A'. The top holds the FSM, counter, registers and final subtraction.

Test Plan:
- x=0xF7, y=0x0A → done, z = 0x00000000000009A5FFFFFFFFFFFFF65A0000000000000000 (= 2470·R⁻¹ mod M).
- x=0x000000000000000100000000000000020000000000000001 (R² mod M), y=0x0B → z = 0x0000000000000000000000000000000B000000000000000B.
- x=y=0x000000000000000000000000000000010000000000000001 (R mod M) → z = 0x000000000000000000000000000000010000000000000001.
- x=R mod M, y=0x0000000000000000000000000000000B000000000000000B → z = 0x0000000000000000000000000000000B000000000000000B. Also check done rises exactly 194 cycles after start is sampled.
- Hold start high for 20 cycles past done → no restart, z stable, done stays 1. Drop start → done=0 the next edge, and a new start launches a fresh operation.
- Assert rst for 1 cycle at iteration 100 → z=0, done=0, FSM in IDLE. The next start with the first vector still yields the first-vector result.
